spi_word_rx: RTL and testbench

//  SPI slave (mode 0: CPOL=0, CPHA=0) that receives the 16-bit DAC command frames sent by the

---
 rtl/spi_word_rx.sv | 184 ++++++++++++++++++
 tb/tb_spi_word_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_word_rx.sv
// ---------------------------------------------------------------------------
// spi_word_rx
//   SPI mode-0 slave that captures WORD_W-bit command frames from the DAC SPI
//   master. The pins are oversampled in the clk domain. Each frame is shifted
//   in MSB-first and split into a 3-bit command and a 12-bit value. Good frames
//   raise a one-cycle word_valid strobe, and frames of the wrong length raise a
//   one-cycle frame_err strobe.
//
//   Optional feature macro: SPI_RX_ECHO_EN
//     defined   - miso_out echoes the previous good word back to the master,
//                 which gives a one-frame-delayed loop-back.
//     undefined - miso_out is tied high, which matches the master's idle MISO.
//
// Ports
//   clk         system clock (>= 4x SCLK)
//   rst         asynchronous, active-low reset
//   sclk_in     SPI clock, idles low
//   ss_in       slave select, active-low
//   mosi_in     serial data from the master
//   miso_out    serial data to the master
//   word_out    last good frame
//   cmd_out     word_out[WORD_W-1 -: 3]
//   value_out   word_out[WORD_W-4 -: 12]
//   word_valid  one-cycle strobe for a new good frame
//   frame_err   one-cycle strobe for a frame with the wrong bit count
//   busy        high while the synchronised SS is low
//   good_cnt    good-frame counter (wraps)
//   err_cnt     bad-frame counter (saturates)
// ---------------------------------------------------------------------------
module spi_word_rx #(
  parameter int WORD_W      = 16,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_in,
  input  logic              ss_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic [WORD_W-1:0] word_out,
  output logic [2:0]        cmd_out,
  output logic [11:0]       value_out,
  output logic              word_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  good_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int BC_W = $clog2(WORD_W + 2);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(WORD_W);
  localparam logic [BC_W-1:0] BC_SAT  = BC_W'(WORD_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, warm;
  logic sclk_s, ss_s, mosi_s;
  logic sclk_prev, ss_prev;
  logic armed;
  logic sclk_rise, ss_fall, ss_rise, mosi_d;
  state_t state;
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0] bitcnt;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Pin synchronisers plus registered edge strobes. MOSI is delayed alongside
  // the SCLK edge strobe so that the shifted bit lines up with its clock edge.
  // The warm chain marks when ss_s holds a real sample rather than its reset
  // value. Frames are accepted only after SS has genuinely been seen high, so
  // a frame that was cut by reset is ignored up to its end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      warm      <= '0;
      sclk_prev <= 1'b0;
      ss_prev   <= 1'b1;
      armed     <= 1'b0;
      sclk_rise <= 1'b0;
      ss_fall   <= 1'b0;
      ss_rise   <= 1'b0;
      mosi_d    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      warm      <= {warm[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_s;
      ss_prev   <= ss_s;
      if (warm[SYNC_STAGES-1] && ss_s) armed <= 1'b1;
      sclk_rise <= sclk_s & ~sclk_prev;
      ss_fall   <= armed & ss_prev & ~ss_s;
      ss_rise   <= ss_s & ~ss_prev;
      mosi_d    <= mosi_s;
      busy      <= ~ss_s;
    end
  end

  // Frame state machine. Shifting happens before the CHECK decision. When an
  // SCLK edge and the SS rise land in the same cycle, CHECK therefore sees the
  // final count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      shreg      <= '0;
      bitcnt     <= '0;
      word_out   <= '0;
      cmd_out    <= '0;
      value_out  <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      good_cnt   <= '0;
      err_cnt    <= '0;
    end else begin
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (ss_fall) begin
            shreg  <= '0;
            bitcnt <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shreg <= {shreg[WORD_W-2:0], mosi_d};
            // Saturating one past full keeps overruns distinguishable.
            if (bitcnt != BC_SAT) bitcnt <= bitcnt + BC_W'(1);
          end
          if (ss_rise) state <= CHECK;
        end
        CHECK: begin
          if (bitcnt == BC_FULL) begin
            word_out   <= shreg;
            cmd_out    <= shreg[WORD_W-1 -: 3];
            value_out  <= shreg[WORD_W-4 -: 12];
            word_valid <= 1'b1;
            good_cnt   <= good_cnt + CNT_W'(1);
          end else begin
            frame_err <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
          end
          // A new frame that starts right behind the old one must not be lost.
          if (ss_fall) begin
            shreg  <= '0;
            bitcnt <= '0;
            state  <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_RX_ECHO_EN
  // Echo path. It uses the unregistered edges so that the next bit is on MISO
  // well before the master's next rising SCLK edge.
  logic [WORD_W-1:0] tx_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_reg <= '0;
    end else if (armed && ss_prev && !ss_s) begin
      tx_reg <= word_out;
    end else if (state == SHIFT && sclk_prev && !sclk_s) begin
      tx_reg <= {tx_reg[WORD_W-2:0], 1'b0};
    end
  end

  assign miso_out = ~ss_s & tx_reg[WORD_W-1];
`else
  assign miso_out = 1'b1;
`endif

endmodule

// File: tb/tb_spi_word_rx.sv
// Directed testbench for spi_word_rx. A frame-level reference model predicts
// the strobes, the word and the counters. The outputs are compared on every
// falling clk edge.
module tb_spi_word_rx;
  localparam int WORD_W = 16;
  localparam int LAT    = 4;   // SYNC_STAGES + 2
`ifdef SPI_RX_ECHO_EN
  localparam int GOOD_BEFORE_T6 = 3;
`else
  localparam int GOOD_BEFORE_T6 = 1;
`endif

  logic clk = 1'b0, rst = 1'b0, sclk_in = 1'b0, ss_in = 1'b1, mosi_in = 1'b0;
  logic miso_out, word_valid, frame_err, busy;
  logic [15:0] word_out, good_cnt, err_cnt;
  logic [2:0] cmd_out;
  logic [11:0] value_out;
  logic miso4, wv4, fe4, busy4;
  logic [15:0] word4;
  logic [2:0] cmd4;
  logic [11:0] val4;
  logic [3:0] good4, err4;

  always #5 clk = ~clk;

  spi_word_rx #(.WORD_W(16), .SYNC_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .ss_in(ss_in), .mosi_in(mosi_in),
    .miso_out(miso_out), .word_out(word_out), .cmd_out(cmd_out), .value_out(value_out),
    .word_valid(word_valid), .frame_err(frame_err), .busy(busy),
    .good_cnt(good_cnt), .err_cnt(err_cnt));

  spi_word_rx #(.WORD_W(16), .SYNC_STAGES(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .sclk_in(sclk_in), .ss_in(ss_in), .mosi_in(mosi_in),
    .miso_out(miso4), .word_out(word4), .cmd_out(cmd4), .value_out(val4),
    .word_valid(wv4), .frame_err(fe4), .busy(busy4),
    .good_cnt(good4), .err_cnt(err4));

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int cyc = 0, nbits = 0, m_good = 0, m_err = 0;
  bit armed = 0, active = 0, m_valid = 0, m_ferr = 0, m_busy = 0;
  logic s_prev = 1'b1, k_prev = 1'b0;
  logic [1:0] ss_hist = 2'b11;
  logic [31:0] bits = '0;
  logic [15:0] m_word = '0;
  int due_q[$];
  bit good_q[$];
  logic [15:0] w_q[$];

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        cyc = 0; nbits = 0; m_good = 0; m_err = 0; armed = 0; active = 0;
        m_valid = 0; m_ferr = 0; m_busy = 0; s_prev = 1'b1; k_prev = 1'b0;
        ss_hist = 2'b11; bits = '0; m_word = '0;
        due_q.delete(); good_q.delete(); w_q.delete();
      end else begin
        cyc++;
        m_valid = 0;
        m_ferr  = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          void'(due_q.pop_front());
          if (good_q.pop_front()) begin
            m_word = w_q.pop_front(); m_good++; m_valid = 1;
          end else begin
            void'(w_q.pop_front()); m_err++; m_ferr = 1;
          end
        end
        m_busy  = ~ss_hist[1];
        ss_hist = {ss_hist[0], ss_in};
        if (active) begin
          if (sclk_in && !k_prev) begin
            bits = {bits[30:0], mosi_in};
            nbits++;
          end
          if (ss_in && !s_prev) begin
            due_q.push_back(cyc + LAT);
            good_q.push_back(nbits == WORD_W);
            w_q.push_back(bits[15:0]);
            active = 0;
          end
        end else if (armed && !ss_in && s_prev) begin
          active = 1; nbits = 0; bits = '0;
        end
        if (ss_in) armed = 1;
        s_prev = ss_in;
        k_prev = sclk_in;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_on = 0, wrap_seen = 0;
  int vw_cnt = 0, fe_cnt = 0;
  logic [3:0] good4_prev = '0;

  always @(negedge clk) begin
    vw_cnt += int'(word_valid);
    fe_cnt += int'(frame_err);
    if (good4_prev == 4'd15 && good4 == 4'd0) wrap_seen = 1;
    good4_prev = good4;
    if (cmp_on) begin
      chk("word_valid", 32'(word_valid), 32'(m_valid));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("strobe_excl", 32'(word_valid & frame_err), 32'd0);
      chk("word_out", 32'(word_out), 32'(m_word));
      chk("cmd_out", 32'(cmd_out), 32'(m_word[15:13]));
      chk("value_out", 32'(value_out), 32'(m_word[12:1]));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("good_cnt", 32'(good_cnt), 32'(m_good % 65536));
      chk("err_cnt", 32'(err_cnt), 32'((m_err > 65535) ? 65535 : m_err));
      chk("good_cnt4", 32'(good4), 32'(m_good % 16));
      chk("err_cnt4", 32'(err4), 32'((m_err > 15) ? 15 : m_err));
`ifndef SPI_RX_ECHO_EN
      chk("miso_tied", 32'(miso_out), 32'd1);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] data, input int nb, input int gap,
                            output int lat, output logic [31:0] miso_bits);
    lat = -1;
    miso_bits = '0;
    tick(1);
    ss_in = 1'b0;
    tick(8);
    for (int i = nb - 1; i >= 0; i--) begin
      mosi_in = data[i];
      tick(4);
      miso_bits = {miso_bits[30:0], miso_out};
      sclk_in = 1'b1;
      tick(4);
      sclk_in = 1'b0;
    end
    tick(4);
    ss_in = 1'b1;
    for (int c = 1; c <= gap; c++) begin
      tick(1);
      if (lat < 0 && (word_valid || frame_err)) lat = c - 1;
    end
  endtask

  int lat, v0, f0;
  logic [31:0] mb;

  initial begin
    tick(3);
    cmp_on = 1;
    tick(1);
    chk("rst_word", 32'(word_out), 32'd0);
    chk("rst_good", 32'(good_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
`ifdef SPI_RX_ECHO_EN
    chk("rst_miso", 32'(miso_out), 32'd0);
`endif
    rst = 1'b1;
    tick(10);

    // 1: good frame
    v0 = vw_cnt; f0 = fe_cnt;
    send_frame(32'h38AA, 16, 10, lat, mb);
    $display("[TB] t1 frame 38AA lat=%0d word=%h", lat, word_out);
    chk("t1_latency", 32'(lat), 32'(LAT));
    chk("t1_valid_cnt", 32'(vw_cnt - v0), 32'd1);
    chk("t1_err_cnt", 32'(fe_cnt - f0), 32'd0);
    chk("t1_word", 32'(word_out), 32'h38AA);
    chk("t1_cmd", 32'(cmd_out), 32'h1);
    chk("t1_value", 32'(value_out), 32'hC55);
    chk("t1_good", 32'(good_cnt), 32'd1);
`ifndef SPI_RX_ECHO_EN
    chk("t1_miso_idle", mb, 32'h0000FFFF);
`endif

    // 2: short frame
    v0 = vw_cnt; f0 = fe_cnt;
    send_frame(32'h1234, 15, 10, lat, mb);
    $display("[TB] t2 15-bit frame lat=%0d err_cnt=%0d", lat, err_cnt);
    chk("t2_latency", 32'(lat), 32'(LAT));
    chk("t2_err_pulse", 32'(fe_cnt - f0), 32'd1);
    chk("t2_no_valid", 32'(vw_cnt - v0), 32'd0);
    chk("t2_err_cnt", 32'(err_cnt), 32'd1);
    chk("t2_word_held", 32'(word_out), 32'h38AA);

    // 3: overrun, then a good frame after one SCLK period of SS high
    v0 = vw_cnt; f0 = fe_cnt;
    send_frame(32'h1ABCD, 17, 7, lat, mb);
    send_frame(32'h2800, 16, 10, lat, mb);
    $display("[TB] t3 17-bit + 2800 word=%h err_cnt=%0d", word_out, err_cnt);
    chk("t3_err_pulse", 32'(fe_cnt - f0), 32'd1);
    chk("t3_valid_pulse", 32'(vw_cnt - v0), 32'd1);
    chk("t3_word", 32'(word_out), 32'h2800);
    chk("t3_cmd", 32'(cmd_out), 32'h1);
    chk("t3_value", 32'(value_out), 32'h400);
    chk("t3_err_cnt", 32'(err_cnt), 32'd2);

    // 4: reset in the middle of a frame
    tick(1);
    ss_in = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      mosi_in = 1'b1; tick(4); sclk_in = 1'b1; tick(4); sclk_in = 1'b0;
    end
    rst = 1'b0;
    tick(1);
    chk("t4_rst_word", 32'(word_out), 32'd0);
    chk("t4_rst_good", 32'(good_cnt), 32'd0);
    chk("t4_rst_err", 32'(err_cnt), 32'd0);
    chk("t4_rst_busy", 32'(busy), 32'd0);
    tick(2);
    rst = 1'b1;
    v0 = vw_cnt; f0 = fe_cnt;
    for (int i = 0; i < 8; i++) begin
      mosi_in = 1'b1; tick(4); sclk_in = 1'b1; tick(4); sclk_in = 1'b0;
    end
    tick(4);
    ss_in = 1'b1;
    tick(12);
    chk("t4_abort_quiet", 32'(vw_cnt - v0 + fe_cnt - f0), 32'd0);
    send_frame(32'h3000, 16, 10, lat, mb);
    $display("[TB] t4 after reset word=%h good=%0d", word_out, good_cnt);
    chk("t4_word", 32'(word_out), 32'h3000);
    chk("t4_good", 32'(good_cnt), 32'd1);

`ifdef SPI_RX_ECHO_EN
    // 5: echo of the previous good word
    send_frame(32'h38AA, 16, 10, lat, mb);
    send_frame(32'h2000, 16, 10, lat, mb);
    $display("[TB] t5 echo miso=%h", mb[15:0]);
    chk("t5_echo", 32'(mb[15:0]), 32'h38AA);
`endif

    // 6: counter wrap and saturation on the CNT_W=4 instance
    for (int i = 0; i < 16; i++) begin
      send_frame(32'(i * 16'h0111), 16, 10, lat, mb);
      $display("[TB] t6 good frame %0d good4=%0d", i, good4);
    end
    for (int i = 0; i < 16; i++) begin
      send_frame(32'h0, 0, 10, lat, mb);
      $display("[TB] t6 zero-bit frame %0d err4=%0d", i, err4);
    end
    chk("t6_wrap_seen", 32'(wrap_seen), 32'd1);
    chk("t6_good4", 32'(good4), 32'((GOOD_BEFORE_T6 + 16) % 16));
    chk("t6_err4_sat", 32'(err4), 32'd15);
    chk("t6_err16", 32'(err_cnt), 32'd16);
    chk("t6_zero_lat", 32'(lat), 32'(LAT));

    tick(10);
    cmp_on = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
